// File: rtl/gt_readout_ctrl_if.sv
// gt_readout_ctrl_if
//   Bundles the GarbledTables read port and the outgoing row stream of the
//   readout controller.
//   rd_addr   : GarbledTables read address (driven by the controller)
//   rd_data   : row read back, combinational from rd_addr
//   out_data  : row payload presented to the host
//   out_valid : payload valid
//   out_ready : host accepts; a transfer occurs when out_valid & out_ready
//   out_last  : marks the final row of a readout
//   master = controller side, slave = memory/host side.
interface gt_readout_ctrl_if #(
    parameter int unsigned S = 20,
    parameter int unsigned K = 128
);
    logic [S-1:0] rd_addr;
    logic [K-1:0] rd_data;
    logic [K-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/gt_readout_ctrl.sv
// gt_readout_ctrl
//   Streams garbled-table rows out of the GarbledTables DPRAM to the host.
//   Each non-XOR gate owns two rows (2g: t0, 2g+1: t1), so a readout covers
//   2*gt_count rows, one per cycle while the host keeps out_ready high.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : begin a readout (sampled in IDLE only)
//   abort    : synchronous cancel, back to IDLE without a done pulse
//   gt_count : number of garbled tables, latched on start
//   bus      : read port + row stream (see gt_readout_ctrl_if)
//   busy     : high whenever the controller is not IDLE
//   done     : one-cycle pulse when a readout completes
module gt_readout_ctrl #(
    parameter int unsigned S = 20,
    parameter int unsigned K = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [S-1:0]        gt_count,
    gt_readout_ctrl_if.master   bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t       state;
    logic [S-1:0] rows;
    logic [S-1:0] r;
    logic [S-1:0] r_next;
    logic [S-1:0] rows_in;
    logic         load;
    logic         xfer;

    // Two rows per table; the top bit of gt_count falls off (wraps) by design.
    assign rows_in = gt_count << 1;
    assign r_next  = r + 1'b1;

    // r only moves on a load, so the address stays put while the sink stalls.
    assign bus.rd_addr = (state == READ) ? r : '0;

    assign xfer = bus.out_valid & bus.out_ready;
    assign load = (state == READ) & (~bus.out_valid | bus.out_ready) & (r < rows);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rows          <= '0;
            r             <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        rows <= rows_in;
                        r    <= '0;
                        busy <= 1'b1;
                        if (rows_in == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    if (abort) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        if (load) begin
                            bus.out_data  <= bus.rd_data;
                            bus.out_valid <= 1'b1;
                            // r < rows holds here, so r+1 == rows marks the final row.
                            bus.out_last  <= (r_next == rows);
                            r             <= r_next;
                        end else if (xfer) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end
                        if (xfer && bus.out_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    busy          <= 1'b0;
                end

                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gt_readout_ctrl.sv
// tb_gt_readout_ctrl
//   Self-checking bench for gt_readout_ctrl. A table of readout cases plus
//   randomized ones are run through one driver/checker; the memory contents
//   are a fixed function of the address, and the expected stream is simply
//   rows 0..2*gt_count-1 in order, each row once, last flagged, then done.
module tb_gt_readout_ctrl;

    localparam int S = 20;
    localparam int K = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [S-1:0] gt_count = '0;
    logic         ready = 1'b0;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    gt_readout_ctrl_if #(.S(S), .K(K)) bus ();

    gt_readout_ctrl #(.S(S), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .gt_count (gt_count),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [K-1:0] mem_row(input logic [S-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w * 32'h9E37_79B1, w ^ 32'hDEAD_BEEF, ~w, w + 32'h0123_4567};
    endfunction

    assign bus.rd_data   = mem_row(bus.rd_addr);
    assign bus.out_ready = ready;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one readout from IDLE and checks it against the expected row list.
    // mode: 0 ready always high, 1 ready pattern 1,0,0,1..., 2 random ready.
    task automatic run_case(input int gc, input int mode, input int abort_after,
                            input int restart_gc, input int exp_lat, input int max_cyc);
        int           rows;
        int           t;
        int           got;
        int           lat;
        int           first_v;
        bit           seen_done;
        bit           aborted;
        bit           rdy;
        bit           prev_stall;
        logic [K-1:0] prev_data;
        logic         prev_last;
        logic [S-1:0] prev_addr;

        rows       = (gc * 2) % (1 << S);
        gt_count   = S'(gc);
        start      = 1'b1;
        ready      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        t          = 0;
        got        = 0;
        lat        = -1;
        first_v    = -1;
        seen_done  = 1'b0;
        aborted    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        prev_addr  = '0;
        while (!seen_done && !aborted && t < max_cyc) begin
            start = 1'b0;
            abort = 1'b0;
            if (restart_gc >= 0 && t == 2) begin
                start    = 1'b1;
                gt_count = S'(restart_gc);
            end
            check("busy_active", busy, 1);
            if (bus.out_valid && first_v < 0) first_v = t;
            if (rows == 0) check("no_valid_empty", bus.out_valid, 0);
            if (prev_stall) begin
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
                check("hold_addr", bus.rd_addr, prev_addr);
            end
            if (done) begin
                seen_done = 1'b1;
                lat       = t;
                check("rows_before_done", got, rows);
                check("valid_in_done", bus.out_valid, 0);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (t % 4 == 0) || (t % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (!seen_done && abort_after >= 0 && got == abort_after) begin
                abort   = 1'b1;
                rdy     = 1'b0;
                aborted = 1'b1;
            end
            ready = rdy;
            if (bus.out_valid && rdy) begin
                check("row_data", bus.out_data, mem_row(S'(got)));
                check("row_last", bus.out_last, got == rows - 1);
                got++;
            end
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_addr  = bus.rd_addr;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        if (aborted) begin
            check("abort_valid", bus.out_valid, 0);
            check("abort_last", bus.out_last, 0);
            check("abort_busy", busy, 0);
            check("abort_addr", bus.rd_addr, 0);
            check("abort_rows", got, abort_after);
            repeat (3) begin
                check("abort_no_done", done, 0);
                check("abort_no_valid", bus.out_valid, 0);
                @(posedge clk);
                @(negedge clk);
            end
        end else begin
            check("done_seen", seen_done, 1);
            if (seen_done) begin
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                check("addr_idle", bus.rd_addr, 0);
                check("rows_delivered", got, rows);
                if (exp_lat >= 0) check("done_latency", lat, exp_lat);
                if (mode == 0 && rows > 0) check("first_valid_latency", first_v, 1);
            end
        end
    endtask

    typedef struct {
        int gc;
        int mode;
        int abort_after;
        int restart_gc;
        int exp_lat;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        // {gt_count, ready mode, abort after N rows, restart gt_count, done latency}
        vecs[0] = '{3,       0, -1, -1, 7};
        vecs[1] = '{2,       1, -1, -1, -1};
        vecs[2] = '{0,       0, -1, -1, 0};
        vecs[3] = '{1,       0, -1, -1, 3};
        vecs[4] = '{5,       1, -1, -1, -1};
        vecs[5] = '{4,       0,  2, -1, -1};
        vecs[6] = '{1,       0, -1, -1, 3};
        vecs[7] = '{2,       0, -1,  5, 5};
        vecs[8] = '{1 << 19, 0, -1, -1, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_addr", bus.rd_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_case(vecs[i].gc, vecs[i].mode, vecs[i].abort_after,
                     vecs[i].restart_gc, vecs[i].exp_lat, 200);

        // start together with abort in IDLE: abort wins
        start    = 1'b1;
        abort    = 1'b1;
        gt_count = S'(2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) begin
            check("start_abort_busy", busy, 0);
            check("start_abort_done", done, 0);
            check("start_abort_valid", bus.out_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end

        // Asynchronous reset mid-stream
        gt_count = S'(4);
        start    = 1'b1;
        ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_valid", bus.out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", bus.rd_addr, 0);
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", bus.out_valid, 0);
        run_case(2, 0, -1, -1, 5, 200);

        // Randomized readouts
        for (int i = 0; i < 25; i++)
            run_case(int'($urandom_range(0, 7)), 2, -1, -1, -1, 300);
        for (int i = 0; i < 6; i++) begin
            int g;
            g = int'($urandom_range(2, 7));
            run_case(g, 2, int'($urandom_range(0, 2 * g - 1)), -1, -1, 300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
